// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIVZERO_CHECK_EN: short-circuit divide-by-zero with a div_by_zero flag.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             accept;
    logic             dz_start;
    logic             iterate;

    assign accept  = start && (state != CALC);
    assign iterate = (state == CALC) && (count != '0);

`ifdef DIVZERO_CHECK_EN
    assign dz_start = (divisor == '0);
`else
    assign dz_start = 1'b0;
`endif

    // Trial subtraction as a two's-complement add with carry-in 1.
    always_comb begin
        r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial   = r_shift + ~{1'b0, d_reg} + {{WIDTH{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = dz_start ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = dz_start ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
            d_reg <= '0;
            r_reg <= '0;
            count <= '0;
        end else if (accept) begin
            d_reg <= divisor;
            if (dz_start) begin
                q_reg <= '1;
                r_reg <= {1'b0, dividend};
                count <= '0;
            end else begin
                q_reg <= dividend;
                r_reg <= '0;
                count <= CW'(WIDTH);
            end
        end else if (iterate) begin
            if (!trial[WIDTH]) begin
                r_reg <= trial;
                q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
                r_reg <= r_shift;
                q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end
            count <= count - CW'(1);
        end
    end

`ifdef DIVZERO_CHECK_EN
    logic dz_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dz_reg <= 1'b0;
        end else if (accept) begin
            dz_reg <= dz_start;
        end
    end

    assign div_by_zero = dz_reg;
`else
    assign div_by_zero = 1'b0;
`endif

    // The count==0 CALC cycle is a settle cycle: busy drops one cycle before done.
    assign busy      = iterate;
    assign done      = (state == DONE);
    assign quotient  = q_reg;
    assign remainder = r_reg[WIDTH-1:0];

endmodule
